// File: rtl/rect_draw_engine.sv
// Rectangle rasteriser: one registered pixel slot per cycle, column-major scan, fill or outline.
// Optional RECT_DRAW_STALL_EN adds a ready input that holds an unaccepted pixel write.
module rect_draw_engine #(
    parameter int COORD_W = 10,
    parameter int DIM_W   = 7,
    parameter int COLOR_W = 3
) (
    input  logic               clk,
    input  logic               resetn,
`ifdef RECT_DRAW_STALL_EN
    input  logic               ready,
`endif
    input  logic               start,
    input  logic [COORD_W-1:0] x_in,
    input  logic [COORD_W-1:0] y_in,
    input  logic [DIM_W-1:0]   w_in,
    input  logic [DIM_W-1:0]   h_in,
    input  logic [COLOR_W-1:0] color_in,
    input  logic               outline,
    output logic               busy,
    output logic               done,
    output logic               writeEn,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    output logic [COLOR_W-1:0] color
);
    // state  | meaning
    // IDLE   | waiting for start; latches the request
    // DRAW   | presenting one pixel slot per cycle
    // FINISH | pulses done, drops busy
    typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

    localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

    state_t             state, state_nxt;
    logic [COORD_W-1:0] x_q, x_nxt, y_q, y_nxt;
    logic [DIM_W-1:0]   w_q, w_nxt, h_q, h_nxt, cx, cx_nxt, cy, cy_nxt;
    logic [COLOR_W-1:0] c_q, c_nxt;
    logic               o_q, o_nxt;
    logic               busy_nxt, done_nxt, we_nxt;
    logic [COORD_W-1:0] x_out_nxt, y_out_nxt;
    logic [COLOR_W-1:0] color_nxt;
    logic               stall, on_border;

`ifdef RECT_DRAW_STALL_EN
    assign stall = writeEn & ~ready;
`else
    assign stall = 1'b0;
`endif

    assign on_border = (cx == '0) || (cx == w_q - ONE) || (cy == '0) || (cy == h_q - ONE);

    always_comb begin
        state_nxt = state;
        x_nxt     = x_q;
        y_nxt     = y_q;
        w_nxt     = w_q;
        h_nxt     = h_q;
        c_nxt     = c_q;
        o_nxt     = o_q;
        cx_nxt    = cx;
        cy_nxt    = cy;
        busy_nxt  = busy;
        done_nxt  = 1'b0;
        we_nxt    = writeEn;
        x_out_nxt = x_out;
        y_out_nxt = y_out;
        color_nxt = color;
        case (state)
            IDLE: begin
                we_nxt = 1'b0;
                if (start) begin
                    x_nxt     = x_in;
                    y_nxt     = y_in;
                    w_nxt     = w_in;
                    h_nxt     = h_in;
                    c_nxt     = color_in;
                    o_nxt     = outline;
                    cx_nxt    = '0;
                    cy_nxt    = '0;
                    busy_nxt  = 1'b1;
                    state_nxt = (w_in == '0 || h_in == '0) ? FINISH : DRAW;
                end
            end
            DRAW: begin
                if (!stall) begin
                    // Coordinates wrap naturally at COORD_W bits; no clipping.
                    x_out_nxt = x_q + COORD_W'(cx);
                    y_out_nxt = y_q + COORD_W'(cy);
                    color_nxt = c_q;
                    we_nxt    = !o_q || on_border;
                    if (cy == h_q - ONE) begin
                        cy_nxt = '0;
                        if (cx == w_q - ONE) state_nxt = FINISH;
                        else                 cx_nxt    = cx + ONE;
                    end else begin
                        cy_nxt = cy + ONE;
                    end
                end
            end
            FINISH: begin
                // The last slot may still be waiting on ready here.
                if (!stall) begin
                    we_nxt    = 1'b0;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            w_q     <= '0;
            h_q     <= '0;
            c_q     <= '0;
            o_q     <= 1'b0;
            cx      <= '0;
            cy      <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            writeEn <= 1'b0;
            x_out   <= '0;
            y_out   <= '0;
            color   <= '0;
        end else begin
            state   <= state_nxt;
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            w_q     <= w_nxt;
            h_q     <= h_nxt;
            c_q     <= c_nxt;
            o_q     <= o_nxt;
            cx      <= cx_nxt;
            cy      <= cy_nxt;
            busy    <= busy_nxt;
            done    <= done_nxt;
            writeEn <= we_nxt;
            x_out   <= x_out_nxt;
            y_out   <= y_out_nxt;
            color   <= color_nxt;
        end
    end
endmodule

// File: tb/tb_rect_draw_engine.sv
// Bench for rect_draw_engine: directed and random draws against a loop-based pixel model.
module tb_rect_draw_engine;
    logic       clk = 1'b0;
    logic       resetn;
    logic       ready;
    logic       start;
    logic [9:0] x_in, y_in;
    logic [6:0] w_in, h_in;
    logic [2:0] color_in;
    logic       outline;
    logic       busy, done, write_en;
    logic [9:0] x_out, y_out;
    logic [2:0] color;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rect_draw_engine #(.COORD_W(10), .DIM_W(7), .COLOR_W(3)) dut (
        .clk     (clk),
        .resetn  (resetn),
`ifdef RECT_DRAW_STALL_EN
        .ready   (ready),
`endif
        .start   (start),
        .x_in    (x_in),
        .y_in    (y_in),
        .w_in    (w_in),
        .h_in    (h_in),
        .color_in(color_in),
        .outline (outline),
        .busy    (busy),
        .done    (done),
        .writeEn (write_en),
        .x_out   (x_out),
        .y_out   (y_out),
        .color   (color)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_start(input logic [9:0] x, input logic [9:0] y, input logic [6:0] w,
                               input logic [6:0] h, input logic [2:0] c, input logic o);
        x_in = x; y_in = y; w_in = w; h_in = h; color_in = c; outline = o; start = 1'b1;
    endtask

    // Slots are {writeEn, x, y, colour}; a slot completes when it is not a stalled write.
    task automatic run_draw(input logic [9:0] x, input logic [9:0] y, input logic [6:0] w,
                            input logic [6:0] h, input logic [2:0] c, input logic o,
                            input int stall_slot, input int stall_len);
        logic [23:0] exp_q[$];
        logic [23:0] got_q[$];
        int n, stalls_left, extra, busy_cnt, done_k, limit;
        logic we, rdy;
        n = int'(w) * int'(h);
        for (int cx = 0; cx < int'(w); cx++)
            for (int cy = 0; cy < int'(h); cy++) begin
                we = !o || cx == 0 || cx == int'(w) - 1 || cy == 0 || cy == int'(h) - 1;
                exp_q.push_back({we, 10'((int'(x) + cx) % 1024), 10'((int'(y) + cy) % 1024), c});
            end
        extra = (stall_slot >= 0 && stall_slot < n && exp_q[stall_slot][23]) ? stall_len : 0;
        stalls_left = stall_len;
        busy_cnt = 0;
        done_k = -1;
        limit = n + stall_len + 20;
        drive_start(x, y, w, h, c, o);
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < limit; k++) begin
            if (done) begin
                done_k = k;
                break;
            end
            if (busy) busy_cnt++;
            rdy = 1'b1;
            if (k >= 1 && got_q.size() < n) begin
                if (got_q.size() == stall_slot && write_en && stalls_left > 0) begin
                    rdy = 1'b0;
                    stalls_left--;
                end
                if (!(write_en && !rdy)) got_q.push_back({write_en, x_out, y_out, color});
            end
            ready = rdy;
            // Inputs and extra starts while busy must have no effect.
            if (k < n) begin
                x_in = 10'($urandom); y_in = 10'($urandom);
                w_in = 7'($urandom); h_in = 7'($urandom);
                color_in = 3'($urandom); outline = 1'($urandom);
                start = ($urandom_range(0, 3) == 0);
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        ready = 1'b1;
        if (done_k < 0) begin
            check("done_timeout", 0, 1);
        end else begin
            check("done_latency", done_k, n + extra + 1);
            check("busy_cycles", busy_cnt, n + extra + 1);
            check("busy_at_done", busy, 0);
            check("we_at_done", write_en, 0);
        end
        check("slot_count", got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) check("slot", got_q[i], exp_q[i]);
        @(negedge clk);
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        int n_wr;
        resetn = 1'b0; ready = 1'b1; start = 1'b0;
        x_in = '0; y_in = '0; w_in = '0; h_in = '0; color_in = '0; outline = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_outputs", {busy, done, write_en, x_out, y_out, color}, '0);
        resetn = 1'b1;
        @(negedge clk);

        run_draw(10'd10, 10'd20, 7'd4, 7'd3, 3'b101, 1'b0, -1, 0);
        run_draw(10'd10, 10'd20, 7'd4, 7'd3, 3'b101, 1'b1, -1, 0);
        run_draw(10'd100, 10'd50, 7'd0, 7'd5, 3'b011, 1'b0, -1, 0);
        run_draw(10'd1020, 10'd7, 7'd8, 7'd1, 3'b110, 1'b1, -1, 0);
        run_draw(10'd3, 10'd1022, 7'd1, 7'd5, 3'b001, 1'b1, -1, 0);

        // Abort a 4x3 draw at its fifth pixel.
        drive_start(10'd10, 10'd20, 7'd4, 7'd3, 3'b101, 1'b0);
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_pix5", {write_en, x_out, y_out}, {1'b1, 10'd11, 10'd21});
        resetn = 1'b0;
        @(negedge clk);
        check("abort_outputs", {busy, done, write_en, x_out, y_out, color}, '0);
        resetn = 1'b1;
        n_wr = 0;
        repeat (5) begin
            @(negedge clk);
            if (done || busy || write_en) n_wr++;
        end
        check("abort_quiet", n_wr, 0);
        run_draw(10'd200, 10'd300, 7'd2, 7'd2, 3'b111, 1'b0, -1, 0);

`ifdef RECT_DRAW_STALL_EN
        run_draw(10'd10, 10'd20, 7'd4, 7'd3, 3'b101, 1'b0, 4, 3);
        run_draw(10'd10, 10'd20, 7'd4, 7'd3, 3'b101, 1'b1, 11, 2);
        run_draw(10'd10, 10'd20, 7'd4, 7'd3, 3'b101, 1'b1, 4, 3);
`endif

        for (int t = 0; t < 16; t++) begin
            int ss, sl;
            logic [6:0] w, h;
            w = 7'($urandom_range(0, 6));
            h = 7'($urandom_range(0, 6));
            ss = -1; sl = 0;
`ifdef RECT_DRAW_STALL_EN
            ss = $urandom_range(0, 36);
            sl = $urandom_range(0, 3);
`endif
            run_draw(10'($urandom), 10'($urandom), w, h, 3'($urandom), 1'($urandom), ss, sl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rect_draw_engine.md
Name: rect_draw_engine

Overview:
- Parametrised rectangle rasteriser for the brick/paddle/ball display path.
- Accepts origin, width, height, colour and a fill/outline mode through a start/busy/done handshake.
- Emits one registered pixel write per cycle (x, y, colour, writeEn) toward the VGA adapter.
- Sizes are run-time inputs rather than compile-time brick constants.

Parameters:
COORD_W, 10, width of x/y coordinates
DIM_W, 7, width of w_in/h_in (max dimension 2^DIM_W-1)
COLOR_W, 3, colour width

Ports:
- clk  in  1  clock
- resetn  in  1  reset
- start  in  1  request; sampled only in IDLE
- x_in  in  COORD_W  left column of rectangle
- y_in  in  COORD_W  top row of rectangle
- w_in  in  DIM_W  width in pixels
- h_in  in  DIM_W  height in pixels
- color_in  in  COLOR_W  draw colour
- outline  in  1  1 = border pixels only, 0 = solid fill
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after last pixel slot
- writeEn  out  1  pixel write strobe
- x_out  out  COORD_W  pixel x
- y_out  out  COORD_W  pixel y
- color  out  COLOR_W  pixel colour

Interface: reset resetn, synchronous, active-low; clock clk.

Behaviour:
- Reset: FSM to IDLE; busy, done, writeEn = 0; x_out, y_out, color = 0; internal counters = 0.
- All outputs are registered.

FSM states:
- IDLE
  - If start=1, latch x_in, y_in, w_in, h_in, color_in and outline; set busy=1.
  - If w_in=0 or h_in=0, go to FINISH; else go to DRAW with column counter cx=0 and row counter cy=0.
- DRAW
  - One pixel slot per cycle: x_out=x+cx, y_out=y+cy, color=latched colour.
  - Scan order is column-major: cy increments first; at cy=h-1, cy resets to 0 and cx increments.
  - After slot (w-1, h-1), go to FINISH.
- FINISH
  - done=1 for exactly one cycle; busy=0 on the same edge; return to IDLE.

Timing and masking:
- Latency: start accepted at edge N → first pixel outputs valid after edge N+1.
- Full scan takes w*h cycles; done is asserted the cycle after the last slot.
- Fill mode: writeEn=1 on every slot.
- Outline mode: writeEn=1 only when cx=0, cx=w-1, cy=0 or cy=h-1. Interior slots still take a cycle with writeEn=0, so timing is mode-independent.
- Degenerate sizes: w=1 or h=1 in outline mode writes every pixel.
- Zero size: no writeEn pulses; done follows one cycle after start.

Arithmetic and boundaries:
- Coordinates wrap modulo 2^COORD_W (x=1020, cx=5 → x_out=1).
- No clipping.
- start while busy is ignored; it is not queued.
- Input changes after acceptance have no effect.
- resetn low mid-draw aborts immediately: no done pulse, outputs return to reset values on the next edge.

Optional Feature:
Macro RECT_DRAW_STALL_EN.
- Defined:
  - Adds input port ready (1 bit) from the frame-buffer arbiter.
  - In DRAW, a slot with writeEn=1 and ready=0 holds x_out, y_out, color and writeEn unchanged; counters do not advance.
  - Masked interior slots advance regardless of ready.
  - done is asserted only after the last slot completes.
- Undefined:
  - No ready port; behaviour is identical to ready tied to 1.

Test Plan:
1. Fill: x=10, y=20, w=4, h=3, colour 3'b101, outline=0 → 12 consecutive writeEn cycles.
   - Sequence (10,20), (10,21), (10,22), (11,20) … (13,22).
   - done pulses exactly 1 cycle after (13,22).
   - busy high for 13 cycles.
2. Outline: same rectangle with outline=1 → 12 slots, 10 writeEn pulses; (11,21) and (12,21) are not written.
3. w=0, h=5 with start → zero writeEn pulses, done 1 cycle after start, busy high for 1 cycle.
4. Wrap: x=1020, w=8, h=1 → x_out sequence 1020..1023, 0..3.
   - Second start pulse issued mid-draw is ignored; exactly 8 writes.
5. Reset: resetn low at the 5th pixel of a 4x3 draw → next cycle busy=0, writeEn=0, coordinates 0, no done pulse.
   - A new start afterwards begins cleanly at its origin.
6. With RECT_DRAW_STALL_EN: ready low for 3 cycles on pixel (11,21) of test 1 → that pixel is held 4 cycles, total draw 15 cycles, still 12 unique writes.
